// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// Op encoding follows RV32M funct3; the FSM enum is used by muldiv_unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFixup,
    StDone
  } state_e;

  function automatic logic is_signed_a(op_e op);
    return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
  endfunction

  function automatic logic is_signed_b(op_e op);
    return op inside {OpMul, OpMulh, OpDiv, OpRem};
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement of a WIDTH-bit value.
// Used for operand magnitudes and for the final result sign fix.
module muldiv_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] din_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] dout_o
);

  always_comb begin
    dout_o = neg_i ? (~din_i + WIDTH'(1)) : din_i;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide for RV32M, one result bit per clock.
// Optional ONZC flag output is built only when MULDIV_FLAGS_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned REG_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [2:0]          op_i,
  input  logic [REG_BITS-1:0] A,
  input  logic [REG_BITS-1:0] B,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [REG_BITS-1:0] C
`ifdef MULDIV_FLAGS_EN
  ,
  output logic [3:0]          ONZC
`endif
);

  localparam int unsigned CNT_BITS = $clog2(REG_BITS) + 1;
  localparam int unsigned PW       = 2 * REG_BITS;
  localparam int unsigned SW       = 2 * REG_BITS + 1;
  localparam logic [REG_BITS-1:0] MinVal = {1'b1, {(REG_BITS-1){1'b0}}};

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [SW-1:0]       sr_q, sr_d;
  logic [REG_BITS-1:0] opnd_q, opnd_d;
  op_e                 op_q, op_d;
  logic                neg_res_q, neg_res_d;
  logic [REG_BITS-1:0] c_q, res_d;
  logic                load_res;

  op_e                 op_in;
  logic                neg_a, neg_b, accept;
  logic [REG_BITS-1:0] abs_a, abs_b;
  logic                spec_dz, spec_ovf;
  logic [REG_BITS-1:0] special_res;

  assign op_in   = op_e'(op_i);
  assign neg_a   = is_signed_a(op_in) & A[REG_BITS-1];
  assign neg_b   = is_signed_b(op_in) & B[REG_BITS-1];
  assign ready_o = (state_q == StIdle) & ~rst;
  assign accept  = valid_i & ready_o & ~flush_i;
  assign valid_o = (state_q == StDone);
  assign C       = c_q;

  muldiv_negate #(.WIDTH(REG_BITS)) u_abs_a (.din_i(A), .neg_i(neg_a), .dout_o(abs_a));
  muldiv_negate #(.WIDTH(REG_BITS)) u_abs_b (.din_i(B), .neg_i(neg_b), .dout_o(abs_b));

  // Divide corner cases resolve in the accept cycle without iterating.
  assign spec_dz  = op_in[2] & (B == '0);
  assign spec_ovf = ((op_in == OpDiv) | (op_in == OpRem)) & (A == MinVal) & (B == '1);

  always_comb begin
    if (spec_dz) special_res = op_in[1] ? A : '1;
    else         special_res = op_in[1] ? '0 : MinVal;
  end

  // Multiply step: add multiplicand into the high half, shift {acc, q} right.
  logic [REG_BITS:0] mul_sum;
  logic [SW-1:0]     mul_next;
  assign mul_sum  = sr_q[PW:REG_BITS] + (sr_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {1'b0, mul_sum, sr_q[REG_BITS-1:1]};

  // Restoring divide step: shift in next dividend bit, subtract if it fits.
  logic [REG_BITS:0] rem_sh, rem_new;
  logic              rem_ge;
  logic [SW-1:0]     div_next;
  assign rem_sh   = {sr_q[PW-1:REG_BITS], sr_q[REG_BITS-1]};
  assign rem_ge   = (rem_sh >= {1'b0, opnd_q});
  assign rem_new  = rem_ge ? (rem_sh - {1'b0, opnd_q}) : rem_sh;
  assign div_next = {rem_new, sr_q[REG_BITS-2:0], rem_ge};

  logic [PW-1:0] res_sel, res_fix;
  assign res_sel = op_q[2] ?
                   {{REG_BITS{1'b0}}, (op_q[1] ? sr_q[PW-1:REG_BITS] : sr_q[REG_BITS-1:0])} :
                   sr_q[PW-1:0];

  muldiv_negate #(.WIDTH(PW)) u_res_fix (.din_i(res_sel), .neg_i(neg_res_q), .dout_o(res_fix));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    res_d     = c_q;
    load_res  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d = op_in;
          if (spec_dz | spec_ovf) begin
            state_d  = StDone;
            res_d    = special_res;
            load_res = 1'b1;
          end else begin
            state_d = StCalc;
            cnt_d   = CNT_BITS'(REG_BITS);
            if (op_in[2]) begin
              sr_d      = {{(REG_BITS+1){1'b0}}, abs_a};
              opnd_d    = abs_b;
              neg_res_d = op_in[1] ? neg_a : (neg_a ^ neg_b);
            end else begin
              sr_d      = {{(REG_BITS+1){1'b0}}, abs_b};
              opnd_d    = abs_a;
              neg_res_d = neg_a ^ neg_b;
            end
          end
        end
      end
      StCalc: begin
        sr_d  = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q - CNT_BITS'(1);
        if (cnt_q == CNT_BITS'(1)) state_d = StFixup;
      end
      StFixup: begin
        state_d  = StDone;
        load_res = 1'b1;
        res_d    = (op_q[2] | (op_q == OpMul)) ? res_fix[REG_BITS-1:0] : res_fix[PW-1:REG_BITS];
      end
      StDone: begin
        if (ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush_i) begin
      state_d  = StIdle;
      cnt_d    = '0;
      load_res = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sr_q      <= '0;
      opnd_q    <= '0;
      op_q      <= OpMul;
      neg_res_q <= 1'b0;
      c_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      if (load_res) c_q <= res_d;
    end
  end

`ifdef MULDIV_FLAGS_EN
  logic [3:0] onzc_q;
  logic       from_special;
  // O and C flags can only come from the special-case path taken in IDLE.
  assign from_special = (state_q == StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      onzc_q <= '0;
    end else if (load_res) begin
      onzc_q <= {spec_ovf & from_special, res_d[REG_BITS-1], ~|res_d, spec_dz & from_special};
    end
  end

  assign ONZC = onzc_q;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at REG_BITS=8 and REG_BITS=32.
// Flag checks are compiled in only when MULDIV_FLAGS_EN is defined.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       flush8 = 0, valid8 = 0, ready8 = 1, ro8, vo8;
  logic [2:0] op8 = 0;
  logic [7:0] a8 = 0, b8 = 0, c8;

  logic        flush32 = 0, valid32 = 0, ready32 = 1, ro32, vo32;
  logic [2:0]  op32 = 0;
  logic [31:0] a32 = 0, b32 = 0, c32;

`ifdef MULDIV_FLAGS_EN
  logic [3:0] onzc8, onzc32;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  muldiv_unit #(.REG_BITS(8)) dut8 (
    .clk(clk), .rst(rst), .flush_i(flush8), .valid_i(valid8), .ready_o(ro8), .op_i(op8),
    .A(a8), .B(b8), .valid_o(vo8), .ready_i(ready8), .C(c8)
`ifdef MULDIV_FLAGS_EN
    , .ONZC(onzc8)
`endif
  );

  muldiv_unit #(.REG_BITS(32)) dut32 (
    .clk(clk), .rst(rst), .flush_i(flush32), .valid_i(valid32), .ready_o(ro32), .op_i(op32),
    .A(a32), .B(b32), .valid_o(vo32), .ready_i(ready32), .C(c32)
`ifdef MULDIV_FLAGS_EN
    , .ONZC(onzc32)
`endif
  );

  // Drives one op at posedge+1; returns at posedge+1 with valid_o high (or budget spent).
  task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      output int lat);
    op8 = op; a8 = a; b8 = b; valid8 = 1;
    @(posedge clk); #1;
    valid8 = 0;
    lat = 1;
    while (!vo8 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    op32 = op; a32 = a; b32 = b; valid32 = 1;
    @(posedge clk); #1;
    valid32 = 0;
    lat = 1;
    while (!vo32 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (ro8 !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b want=0", ro8); end
    n_cmp++; if (vo8 !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b want=0", vo8); end
    n_cmp++; if (c8 !== 8'h00) begin n_fail++; $display("FAIL rst_c got=%h want=00", c8); end
`ifdef MULDIV_FLAGS_EN
    n_cmp++; if (onzc8 !== 4'h0) begin n_fail++; $display("FAIL rst_onzc got=%h want=0", onzc8); end
`endif
    rst = 0;
    #1;
    n_cmp++; if (ro8 !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after got=%b want=1", ro8); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int lat;
    run8(3'b000, 8'h07, 8'hFD, lat);
    n_cmp++; if (c8 !== 8'hEB) begin n_fail++; $display("FAIL mul got=%h want=eb", c8); end
    n_cmp++; if (lat !== 10) begin n_fail++; $display("FAIL mul_lat got=%0d want=10", lat); end
`ifdef MULDIV_FLAGS_EN
    n_cmp++; if (onzc8 !== 4'b0100) begin n_fail++; $display("FAIL mul_flags got=%b want=0100", onzc8); end
`endif
    @(posedge clk); #1;
    run8(3'b011, 8'hFF, 8'hFF, lat);
    n_cmp++; if (c8 !== 8'hFE) begin n_fail++; $display("FAIL mulhu got=%h want=fe", c8); end
    @(posedge clk); #1;
    run8(3'b001, 8'hFF, 8'hFF, lat);
    n_cmp++; if (c8 !== 8'h00) begin n_fail++; $display("FAIL mulh got=%h want=00", c8); end
`ifdef MULDIV_FLAGS_EN
    n_cmp++; if (onzc8 !== 4'b0010) begin n_fail++; $display("FAIL mulh_flags got=%b want=0010", onzc8); end
`endif
    @(posedge clk); #1;
    run8(3'b010, 8'hFF, 8'h02, lat);
    n_cmp++; if (c8 !== 8'hFF) begin n_fail++; $display("FAIL mulhsu got=%h want=ff", c8); end
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    int lat;
    run8(3'b101, 8'd200, 8'd7, lat);
    n_cmp++; if (c8 !== 8'h1C) begin n_fail++; $display("FAIL divu got=%h want=1c", c8); end
    n_cmp++; if (lat !== 10) begin n_fail++; $display("FAIL divu_lat got=%0d want=10", lat); end
    @(posedge clk); #1;
    run8(3'b111, 8'd200, 8'd7, lat);
    n_cmp++; if (c8 !== 8'h04) begin n_fail++; $display("FAIL remu got=%h want=04", c8); end
    @(posedge clk); #1;
    run8(3'b100, 8'hF9, 8'h02, lat);
    n_cmp++; if (c8 !== 8'hFD) begin n_fail++; $display("FAIL div_neg got=%h want=fd", c8); end
    @(posedge clk); #1;
    run8(3'b110, 8'hF9, 8'h02, lat);
    n_cmp++; if (c8 !== 8'hFF) begin n_fail++; $display("FAIL rem_neg got=%h want=ff", c8); end
    @(posedge clk); #1;
  endtask

  task automatic test_special();
    int lat;
    run8(3'b100, 8'h80, 8'hFF, lat);
    n_cmp++; if (c8 !== 8'h80) begin n_fail++; $display("FAIL div_ovf got=%h want=80", c8); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL div_ovf_lat got=%0d want=1", lat); end
`ifdef MULDIV_FLAGS_EN
    n_cmp++; if (onzc8 !== 4'b1100) begin n_fail++; $display("FAIL ovf_flags got=%b want=1100", onzc8); end
`endif
    @(posedge clk); #1;
    run8(3'b110, 8'h80, 8'hFF, lat);
    n_cmp++; if (c8 !== 8'h00) begin n_fail++; $display("FAIL rem_ovf got=%h want=00", c8); end
    @(posedge clk); #1;
    run8(3'b101, 8'h2A, 8'h00, lat);
    n_cmp++; if (c8 !== 8'hFF) begin n_fail++; $display("FAIL divu_dz got=%h want=ff", c8); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL divu_dz_lat got=%0d want=1", lat); end
`ifdef MULDIV_FLAGS_EN
    n_cmp++; if (onzc8 !== 4'b0101) begin n_fail++; $display("FAIL dz_flags got=%b want=0101", onzc8); end
`endif
    @(posedge clk); #1;
    run8(3'b111, 8'h2A, 8'h00, lat);
    n_cmp++; if (c8 !== 8'h2A) begin n_fail++; $display("FAIL remu_dz got=%h want=2a", c8); end
    @(posedge clk); #1;
    run8(3'b100, 8'hF9, 8'h00, lat);
    n_cmp++; if (c8 !== 8'hFF) begin n_fail++; $display("FAIL div_dz got=%h want=ff", c8); end
    @(posedge clk); #1;
    run8(3'b110, 8'hF9, 8'h00, lat);
    n_cmp++; if (c8 !== 8'hF9) begin n_fail++; $display("FAIL rem_dz got=%h want=f9", c8); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    ready8 = 0;
    run8(3'b000, 8'h05, 8'h06, lat);
    n_cmp++; if (c8 !== 8'h1E) begin n_fail++; $display("FAIL bp_first got=%h want=1e", c8); end
    // Offer a second op while the first result is stalled.
    op8 = 3'b101; a8 = 8'd100; b8 = 8'd9; valid8 = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (vo8 !== 1'b1 || c8 !== 8'h1E || ro8 !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d got v=%b c=%h r=%b want v=1 c=1e r=0", i, vo8, c8, ro8);
      end
`ifdef MULDIV_FLAGS_EN
      n_cmp++; if (onzc8 !== 4'b0000) begin n_fail++; $display("FAIL bp_flags got=%b want=0000", onzc8); end
`endif
    end
    ready8 = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (vo8 !== 1'b0 || ro8 !== 1'b1) begin
      n_fail++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", vo8, ro8);
    end
    @(posedge clk); #1;
    valid8 = 0;
    lat = 1;
    while (!vo8 && lat < 200) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (c8 !== 8'h0B) begin n_fail++; $display("FAIL bp_second got=%h want=0b", c8); end
    n_cmp++; if (lat !== 10) begin n_fail++; $display("FAIL bp_second_lat got=%0d want=10", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    logic seen;
    op8 = 3'b101; a8 = 8'd200; b8 = 8'd7; valid8 = 1;
    @(posedge clk); #1;
    valid8 = 0;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (ro8 !== 1'b0) begin n_fail++; $display("FAIL fl_busy got=%b want=0", ro8); end
    flush8 = 1; valid8 = 1; op8 = 3'b000;
    @(posedge clk); #1;
    flush8 = 0; valid8 = 0;
    n_cmp++;
    if (ro8 !== 1'b1 || vo8 !== 1'b0) begin
      n_fail++; $display("FAIL fl_calc got r=%b v=%b want r=1 v=0", ro8, vo8);
    end
    flush8 = 1; valid8 = 1;
    @(posedge clk); #1;
    flush8 = 0; valid8 = 0;
    n_cmp++; if (ro8 !== 1'b1) begin n_fail++; $display("FAIL fl_idle got=%b want=1", ro8); end
    seen = 0;
    repeat (14) begin @(posedge clk); #1; if (vo8) seen = 1; end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL fl_noresult got=%b want=0", seen); end
  endtask

  task automatic test_reset_mid();
    int lat;
    op8 = 3'b101; a8 = 8'd200; b8 = 8'd7; valid8 = 1;
    @(posedge clk); #1;
    valid8 = 0;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst = 1;
    #1;
    n_cmp++;
    if (ro8 !== 1'b0 || vo8 !== 1'b0 || c8 !== 8'h00) begin
      n_fail++; $display("FAIL rm_async got r=%b v=%b c=%h want r=0 v=0 c=00", ro8, vo8, c8);
    end
    #1 rst = 0;
    @(posedge clk); #1;
    n_cmp++;
    if (ro8 !== 1'b1 || vo8 !== 1'b0) begin
      n_fail++; $display("FAIL rm_after got r=%b v=%b want r=1 v=0", ro8, vo8);
    end
    run8(3'b000, 8'h0C, 8'h0B, lat);
    n_cmp++; if (c8 !== 8'h84) begin n_fail++; $display("FAIL rm_recover got=%h want=84", c8); end
    @(posedge clk); #1;
  endtask

  task automatic test_wide();
    int lat;
    run32(3'b000, 32'h7FFF_FFFF, 32'h0000_0002, lat);
    n_cmp++; if (c32 !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL w_mul got=%h want=fffffffe", c32); end
    n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL w_mul_lat got=%0d want=34", lat); end
    @(posedge clk); #1;
    run32(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    n_cmp++; if (c32 !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL w_mulhu got=%h want=fffffffe", c32); end
    @(posedge clk); #1;
    run32(3'b100, 32'hFFFF_FF9C, 32'd7, lat);
    n_cmp++; if (c32 !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL w_div got=%h want=fffffff2", c32); end
    @(posedge clk); #1;
    run32(3'b110, 32'hFFFF_FF9C, 32'd7, lat);
    n_cmp++; if (c32 !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL w_rem got=%h want=fffffffe", c32); end
    @(posedge clk); #1;
    run32(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    n_cmp++; if (c32 !== 32'h8000_0000) begin n_fail++; $display("FAIL w_ovf got=%h want=80000000", c32); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL w_ovf_lat got=%0d want=1", lat); end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
